sw_debounce: RTL and testbench

//  Conditions the 16 raw board slide switches before they reach the switch-decode/clock-select

---
 rtl/sw_debounce_pkg.sv | 24 ++
 rtl/debounce_bit.sv | 53 +++++
 rtl/sw_debounce.sv | 38 +++
 tb/tb_sw_debounce.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Board-level constants shared by the switch conditioning path and its users.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
package sw_debounce_pkg;

  // Board clock and the debounce window it is measured against.
  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Slide switch assignments as seen by the switch-decode stage.
  localparam int SW_GO      = 0;
  localparam int SW_RST     = 1;
  localparam int SW_SPEED   = 2;
  localparam int SW_DOP_LO  = 3;
  localparam int SW_DOP_HI  = 5;
  localparam int SW_ADDR_LO = 6;
  localparam int SW_ADDR_HI = 15;

  // Converts a millisecond window into board clock cycles.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stable-time filter, registered rise/fall pulses.
// Latency: a change held stable is accepted STABLE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running, the input is sampled every cycle.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  // Count value on which a persistent difference is finally accepted.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept sync2 only after it has differed from clean long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == clean) begin
        // Any bounce back to the accepted level restarts the window.
        cnt <= '0;
      end else if (cnt == LAST) begin
        clean <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches into clean levels plus one-cycle rise/fall pulses.
// Latency: STABLE_CYCLES+2 edges from a stable raw change to sw_clean and its pulse.
// Backpressure: none; outputs are levels and single-cycle pulses, never stalled.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Bits are fully independent; each gets its own synchronizer and filter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

  // Pulses are registered, so this OR lines up with them in the same cycle.
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int W   = 16;
  localparam int S   = 8;
  localparam int CW  = 4;
  localparam int LAT = S + 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, sw_rise, sw_fall;
  logic         sw_changed;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  // Reference model: a bit flips once the twice-delayed input has disagreed with
  // the accepted level over each of the last S edges (sliding window).
  logic [W-1:0] m_d1 = '0, m_d2 = '0;
  logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
  logic [W-1:0] m_win[$];

  wire [3*W:0] dut_vec = {sw_clean, sw_rise, sw_fall, sw_changed};
  wire [3*W:0] exp_vec = {m_clean, m_rise, m_fall, |(m_rise | m_fall)};

  task automatic model_step();
    logic all_diff;
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
      m_win.delete();
    end else begin
      m_win.push_back(m_d2);
      if (m_win.size() > S) void'(m_win.pop_front());
      m_d2 = m_d1;
      m_d1 = sw_raw;
      m_rise = '0;
      m_fall = '0;
      if (m_win.size() == S) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (m_win[k]) if (m_win[k][b] == m_clean[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_rise[b]  = ~m_clean[b];
            m_fall[b]  = m_clean[b];
            m_clean[b] = ~m_clean[b];
          end
        end
      end
    end
  endtask

  // Advance the model for the coming edge, then wait until after that edge.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_at = -1;
    int n_rise  = 0;
    rst_n  = 1'b0;
    sw_raw = '1;
    repeat (3) begin
      tick();
      n_chk++;
      if (dut_vec !== '0) $display("FAIL reset_hold dut=%h exp=0", dut_vec);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL reset_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_rise != '0) begin
        n_rise++;
        rise_at = i + 1;
        n_chk++;
        if (sw_rise !== 16'hFFFF) $display("FAIL reset_rise_val dut=%h exp=ffff", sw_rise);
        else n_pass++;
      end
    end
    n_chk++;
    if (rise_at !== LAT || n_rise !== 1)
      $display("FAIL reset_latency edge=%0d cycles=%0d exp edge=%0d cycles=1", rise_at, n_rise, LAT);
    else n_pass++;
    n_chk++;
    if (sw_clean !== 16'hFFFF) $display("FAIL reset_clean dut=%h exp=ffff", sw_clean);
    else n_pass++;
  endtask

  task automatic test_clean_step();
    int rise_at = -1;
    int n_rise  = 0;
    int n_chg   = 0;
    logic [W-1:0] noise = '0;
    sw_raw = '0;
    repeat (LAT + 4) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL step_settle dut=%h exp=%h", dut_vec, exp_vec);
      else n_pass++;
    end
    sw_raw[SW_GO] = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL step_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_rise[SW_GO]) begin n_rise++; rise_at = i + 1; end
      if (sw_changed) n_chg++;
      noise |= (sw_rise & ~16'h0001) | sw_fall;
    end
    n_chk++;
    if (rise_at !== LAT || n_rise !== 1 || n_chg !== 1)
      $display("FAIL step_latency edge=%0d rise=%0d chg=%0d exp edge=%0d 1 1", rise_at, n_rise, n_chg, LAT);
    else n_pass++;
    n_chk++;
    if (noise !== '0 || sw_clean !== 16'h0001)
      $display("FAIL step_quiet noise=%h clean=%h exp 0000 0001", noise, sw_clean);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int rise_at = -1;
    int n_rise  = 0;
    int n_fall  = 0;
    sw_raw = '0;
    repeat (LAT + 4) tick();
    for (int i = 0; i < 12 + LAT + 4; i++) begin
      if (i < 12) sw_raw[SW_SPEED] = ((i / 3) % 2 == 0);
      else        sw_raw[SW_SPEED] = 1'b1;
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL bounce_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_rise[SW_SPEED]) begin n_rise++; rise_at = i; end
      if (sw_fall[SW_SPEED]) n_fall++;
    end
    n_chk++;
    if (n_rise !== 1 || rise_at !== 12 + LAT - 1 || n_fall !== 0)
      $display("FAIL bounce_pulse rise=%0d at=%0d fall=%0d exp 1 %0d 0", n_rise, rise_at, n_fall, 12 + LAT - 1);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int n_pulse = 0;
    int n_high  = 0;
    sw_raw = '0;
    repeat (LAT + 4) tick();
    for (int i = 0; i < 7 + LAT + 4; i++) begin
      sw_raw[SW_DOP_HI] = (i < 7);
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL glitch_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_rise[SW_DOP_HI] || sw_fall[SW_DOP_HI]) n_pulse++;
      if (sw_clean[SW_DOP_HI]) n_high++;
    end
    n_chk++;
    if (n_pulse !== 0 || n_high !== 0)
      $display("FAIL glitch_reject pulses=%0d clean_high=%0d exp 0 0", n_pulse, n_high);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int n_chg  = 0;
    int chg_at = -1;
    logic [W-1:0] cap_rise = '0, cap_fall = '0;
    sw_raw = '0;
    sw_raw[SW_DOP_LO] = 1'b1;
    repeat (LAT + 4) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL simul_settle dut=%h exp=%h", dut_vec, exp_vec);
      else n_pass++;
    end
    sw_raw = '0;
    sw_raw[SW_RST]     = 1'b1;
    sw_raw[SW_ADDR_HI] = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL simul_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_changed) begin
        n_chg++;
        chg_at   = i;
        cap_rise = sw_rise;
        cap_fall = sw_fall;
      end
    end
    n_chk++;
    if (n_chg !== 1 || chg_at !== LAT - 1)
      $display("FAIL simul_changed count=%0d at=%0d exp 1 %0d", n_chg, chg_at, LAT - 1);
    else n_pass++;
    n_chk++;
    if (cap_rise !== 16'h8002 || cap_fall !== 16'h0008)
      $display("FAIL simul_pulses rise=%h fall=%h exp 8002 0008", cap_rise, cap_fall);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rise_at = -1;
    int n_rise  = 0;
    sw_raw = '0;
    repeat (LAT + 4) tick();
    sw_raw[SW_ADDR_LO] = 1'b1;
    for (int i = 0; i < 6 + LAT + 4; i++) begin
      if (i == 5) rst_n = 1'b0;
      if (i == 6) rst_n = 1'b1;
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL rstmid_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (i == 5) begin
        n_chk++;
        if (dut_vec !== '0) $display("FAIL rstmid_cleared dut=%h exp=0", dut_vec);
        else n_pass++;
      end
      if (sw_rise[SW_ADDR_LO]) begin n_rise++; rise_at = i; end
    end
    n_chk++;
    if (n_rise !== 1 || rise_at !== 6 + LAT - 1)
      $display("FAIL rstmid_latency rise=%0d at=%0d exp 1 %0d", n_rise, rise_at, 6 + LAT - 1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] mask;
    int n_acc = 0;
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      mask  = '0;
      for (int b = 0; b < W; b++)
        mask[b] = (((i / 100) % 2) != 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
      sw_raw ^= mask;
      tick();
      n_chk++;
      if (dut_vec !== exp_vec) $display("FAIL random_model i=%0d dut=%h exp=%h", i, dut_vec, exp_vec);
      else n_pass++;
      if (sw_changed) n_acc++;
    end
    rst_n = 1'b1;
    n_chk++;
    if (n_acc == 0) $display("FAIL random_activity accepted=%0d exp >0", n_acc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
